// File: rtl/sico_rec_pkg.sv
// Shared constants and helpers for the multi-channel clocked recorder.
// Contents:
//   MODE_ALL / MODE_CHANGE : recording mode selectors
//   STAMP_W                : width of the cycle stamp
//   chan_w()               : channel index width, never below 1
package sico_rec_pkg;

  localparam int unsigned MODE_ALL    = 0;
  localparam int unsigned MODE_CHANGE = 1;
  localparam int unsigned STAMP_W     = 64;

  function automatic int unsigned chan_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sico_rec_fifo.sv
// Generic first-word-fall-through synchronous FIFO.
// Ports:
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset, empties the FIFO
//   push_i  : write din_i (accepted when not full, or full with a pop)
//   din_i   : write data
//   pop_i   : remove head entry (ignored when empty)
//   dout_o  : head entry, forced to zero while empty
//   full_o  : FIFO full
//   empty_o : FIFO empty
module sico_rec_fifo
  import sico_rec_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sico_rec_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // Storage is not reset, so the head is masked to keep outputs zero when empty.
  assign dout_o  = empty_o ? '0 : mem[rd_q];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!do_push && do_pop) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sico_clkd_recorder_mc.sv
// Multi-channel clocked recorder: samples NCH channels each edge, stamps each
// sample with a 64-bit cycle count, parks it in a per-channel pending slot and
// moves one slot per edge (lowest index first) into an event FIFO.
// Optional feature macro: SICO_RECORDER_OVF_FLAG_EN (adds evt_ovf_o).
// Ports:
//   clk_i       : sampling clock
//   rst_i       : asynchronous active-high reset
//   val_i       : channel values, channel n = val_i[n*WIDTH +: WIDTH]
//   evt_valid_o : event available
//   evt_ready_i : sink accepts event
//   evt_chan_o  : channel index of head event
//   evt_cycle_o : cycle stamp of head event
//   evt_val_o   : sampled value of head event
//   drop_cnt_o  : saturating count of overwritten pending samples
//   fifo_full_o : event FIFO full
//   evt_ovf_o   : (macro only) first event after a loss on that channel
module sico_clkd_recorder_mc
  import sico_rec_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned MODE  = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NCH*WIDTH-1:0]   val_i,
  output logic                   evt_valid_o,
  input  logic                   evt_ready_i,
  output logic [chan_w(NCH)-1:0] evt_chan_o,
  output logic [STAMP_W-1:0]     evt_cycle_o,
  output logic [WIDTH-1:0]       evt_val_o,
  output logic [31:0]            drop_cnt_o,
`ifdef SICO_RECORDER_OVF_FLAG_EN
  output logic                   evt_ovf_o,
`endif
  output logic                   fifo_full_o
);

  localparam int unsigned CW = chan_w(NCH);

  if (NCH < 1 || NCH > 32) begin : g_bad_nch
    $error("sico_clkd_recorder_mc: NCH must be 1..32");
  end
  if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
    $error("sico_clkd_recorder_mc: WIDTH must be 1..1024");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sico_clkd_recorder_mc: DEPTH must be a power of two >= 2");
  end

  typedef struct packed {
    logic [CW-1:0]      chan;
    logic [STAMP_W-1:0] stamp;
    logic [WIDTH-1:0]   value;
`ifdef SICO_RECORDER_OVF_FLAG_EN
    logic               ovf;
`endif
  } evt_t;

  localparam int unsigned EW = $bits(evt_t);

  logic [STAMP_W-1:0] stamp_q;
  logic               seen_q;
  logic [WIDTH-1:0]   prev_q       [NCH];
  logic [NCH-1:0]     slot_v_q;
  logic [WIDTH-1:0]   slot_val_q   [NCH];
  logic [STAMP_W-1:0] slot_stamp_q [NCH];
  logic [31:0]        drop_cnt_q;
`ifdef SICO_RECORDER_OVF_FLAG_EN
  logic [NCH-1:0]     slot_ovf_q;
`endif

  logic [NCH-1:0]     sample;
  logic [NCH-1:0]     grant;
  logic [NCH-1:0]     moved;
  logic [NCH-1:0]     drop;
  logic               any_pending;
  logic               move;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [5:0]         ndrop;
  logic [32:0]        drop_sum;
  logic [31:0]        drop_next;
  evt_t               entry;
  evt_t               head;

  always_comb begin
    sample = '0;
    for (int unsigned n = 0; n < NCH; n++) begin
      sample[n] = (MODE == MODE_ALL) || !seen_q ||
                  (val_i[n*WIDTH +: WIDTH] != prev_q[n]);
    end
  end

  // One-hot grant to the lowest-index valid slot.
  always_comb begin
    grant       = '0;
    any_pending = 1'b0;
    for (int unsigned n = 0; n < NCH; n++) begin
      if (slot_v_q[n] && !any_pending) begin
        grant[n]    = 1'b1;
        any_pending = 1'b1;
      end
    end
  end

  assign pop   = evt_valid_o && evt_ready_i;
  assign move  = any_pending && (!fifo_full || pop);
  assign moved = move ? grant : '0;
  // A slot emptied by this edge's move can take a new sample without loss.
  assign drop  = sample & slot_v_q & ~moved;

  always_comb begin
    entry = '0;
    for (int unsigned n = 0; n < NCH; n++) begin
      if (grant[n]) begin
        entry.chan  = n[CW-1:0];
        entry.stamp = slot_stamp_q[n];
        entry.value = slot_val_q[n];
`ifdef SICO_RECORDER_OVF_FLAG_EN
        entry.ovf   = slot_ovf_q[n];
`endif
      end
    end
  end

  always_comb begin
    ndrop = '0;
    for (int unsigned n = 0; n < NCH; n++) begin
      ndrop = ndrop + 6'(drop[n]);
    end
    drop_sum  = {1'b0, drop_cnt_q} + 33'(ndrop);
    drop_next = drop_sum[32] ? '1 : drop_sum[31:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stamp_q    <= '0;
      seen_q     <= 1'b0;
      slot_v_q   <= '0;
      drop_cnt_q <= '0;
`ifdef SICO_RECORDER_OVF_FLAG_EN
      slot_ovf_q <= '0;
`endif
      for (int unsigned n = 0; n < NCH; n++) begin
        prev_q[n]       <= '0;
        slot_val_q[n]   <= '0;
        slot_stamp_q[n] <= '0;
      end
    end else begin
      stamp_q    <= stamp_q + 1'b1;
      seen_q     <= 1'b1;
      slot_v_q   <= sample | (slot_v_q & ~moved);
      drop_cnt_q <= drop_next;
`ifdef SICO_RECORDER_OVF_FLAG_EN
      slot_ovf_q <= drop | (slot_ovf_q & ~moved);
`endif
      for (int unsigned n = 0; n < NCH; n++) begin
        prev_q[n] <= val_i[n*WIDTH +: WIDTH];
        if (sample[n]) begin
          slot_val_q[n]   <= val_i[n*WIDTH +: WIDTH];
          slot_stamp_q[n] <= stamp_q;
        end
      end
    end
  end

  sico_rec_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (move),
    .din_i   (entry),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign evt_valid_o = !fifo_empty;
  assign fifo_full_o = fifo_full;
  assign evt_chan_o  = head.chan;
  assign evt_cycle_o = head.stamp;
  assign evt_val_o   = head.value;
  assign drop_cnt_o  = drop_cnt_q;
`ifdef SICO_RECORDER_OVF_FLAG_EN
  assign evt_ovf_o   = head.ovf;
`endif

endmodule

// File: tb/tb_sico_clkd_recorder_mc.sv
module tb_sico_clkd_recorder_mc;

  logic        clk = 1'b0;
  logic        rst_a;
  logic        rst_b;
  logic [31:0] a_val;
  logic        a_ready;
  logic        a_valid;
  logic [1:0]  a_chan;
  logic [63:0] a_cycle;
  logic [7:0]  a_out;
  logic [31:0] a_drop;
  logic        a_full;
  logic [7:0]  b_val;
  logic        b_ready;
  logic        b_valid;
  logic [0:0]  b_chan;
  logic [63:0] b_cycle;
  logic [7:0]  b_out;
  logic [31:0] b_drop;
  logic        b_full;
`ifdef SICO_RECORDER_OVF_FLAG_EN
  logic        a_ovf;
  logic        b_ovf;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int idle_cnt;

  always #5 clk = ~clk;

  sico_clkd_recorder_mc #(
    .NCH   (4),
    .WIDTH (8),
    .DEPTH (16),
    .MODE  (1)
  ) u_dut_a (
    .clk_i       (clk),
    .rst_i       (rst_a),
    .val_i       (a_val),
    .evt_valid_o (a_valid),
    .evt_ready_i (a_ready),
    .evt_chan_o  (a_chan),
    .evt_cycle_o (a_cycle),
    .evt_val_o   (a_out),
    .drop_cnt_o  (a_drop),
`ifdef SICO_RECORDER_OVF_FLAG_EN
    .evt_ovf_o   (a_ovf),
`endif
    .fifo_full_o (a_full)
  );

  sico_clkd_recorder_mc #(
    .NCH   (1),
    .WIDTH (8),
    .DEPTH (4),
    .MODE  (0)
  ) u_dut_b (
    .clk_i       (clk),
    .rst_i       (rst_b),
    .val_i       (b_val),
    .evt_valid_o (b_valid),
    .evt_ready_i (b_ready),
    .evt_chan_o  (b_chan),
    .evt_cycle_o (b_cycle),
    .evt_val_o   (b_out),
    .drop_cnt_o  (b_drop),
`ifdef SICO_RECORDER_OVF_FLAG_EN
    .evt_ovf_o   (b_ovf),
`endif
    .fifo_full_o (b_full)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int unsigned ch, input logic [7:0] v);
    a_val[ch*8 +: 8] = v;
  endtask

  task automatic chk_a_evt(input string tag, input logic [1:0] ch,
                           input logic [63:0] cyc, input logic [7:0] v);
    chk({tag, "_valid"}, a_valid, 1'b1);
    chk({tag, "_chan"},  a_chan,  ch);
    chk({tag, "_cycle"}, a_cycle, cyc);
    chk({tag, "_val"},   a_out,   v);
  endtask

  initial begin
    rst_a   = 1'b1;
    rst_b   = 1'b1;
    a_val   = {4{8'h05}};
    a_ready = 1'b1;
    b_val   = 8'h00;
    b_ready = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_drop",  a_drop,  32'd0);
    chk("rst_full",  a_full,  1'b0);
    chk("rst_chan",  a_chan,  2'd0);
    chk("rst_cycle", a_cycle, 64'd0);
    chk("rst_val",   a_out,   8'd0);
    chk("rst_b_valid", b_valid, 1'b0);

    // Static input after reset: one event per channel, all stamp 0
    rst_a = 1'b0;
    step();                                   // edge 0
    chk("lat_valid0", a_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();                                 // edges 1..4
      chk_a_evt("static", 2'(i), 64'd0, 8'h05);
    end
    idle_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();                                 // edges 5..7
      if (a_valid) idle_cnt++;
    end
    chk("static_idle", idle_cnt, 0);

    // Channel 2 changes to 0 at stamp 8, then to 1 at stamp 10
    set_a(2, 8'h00);
    step();                                   // edge 8
    chk("ch2a_lat", a_valid, 1'b0);
    step();                                   // edge 9
    chk_a_evt("ch2a", 2'd2, 64'd8, 8'h00);
    set_a(2, 8'h01);
    step();                                   // edge 10
    chk("ch2b_lat", a_valid, 1'b0);
    step();                                   // edge 11
    chk_a_evt("ch2b", 2'd2, 64'd10, 8'h01);
    step();                                   // edge 12
    chk("ch2b_gone", a_valid, 1'b0);

    idle_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      step();                                 // edges 13..19
      if (a_valid) idle_cnt++;
    end
    chk("idle2", idle_cnt, 0);

    // Channels 0 and 3 change at stamp 20; ready toggles 1-0-1
    set_a(0, 8'h0A);
    set_a(3, 8'h0B);
    step();                                   // edge 20
    step();                                   // edge 21
    chk_a_evt("pair0", 2'd0, 64'd20, 8'h0A);
    a_ready = 1'b0;
    step();                                   // edge 22
    chk_a_evt("hold0", 2'd0, 64'd20, 8'h0A);
    a_ready = 1'b1;
    step();                                   // edge 23
    chk_a_evt("pair3", 2'd3, 64'd20, 8'h0B);
    step();                                   // edge 24
    chk("pair_gone", a_valid, 1'b0);

    // Buffer 3 events with one drop, then reset mid-clock
    a_ready = 1'b0;
    set_a(0, 8'h11);
    set_a(1, 8'h22);
    set_a(2, 8'h33);
    step();                                   // edge 25
    set_a(1, 8'h44);
    step();                                   // edge 26: ch1 overwritten
    step();                                   // edge 27
    step();                                   // edge 28
    chk("buf_drop", a_drop, 32'd1);
    chk_a_evt("buf_head", 2'd0, 64'd25, 8'h11);
    #2;
    rst_a = 1'b1;
    #1;
    chk("arst_valid", a_valid, 1'b0);
    chk("arst_drop",  a_drop,  32'd0);
    chk("arst_cycle", a_cycle, 64'd0);
    chk("arst_val",   a_out,   8'd0);
    step();
    rst_a   = 1'b0;
    a_ready = 1'b1;
    step();                                   // edge 0
    step();                                   // edge 1
    chk_a_evt("post0", 2'd0, 64'd0, 8'h11);
    step();
    chk_a_evt("post1", 2'd1, 64'd0, 8'h44);
    step();
    chk_a_evt("post2", 2'd2, 64'd0, 8'h33);
    step();
    chk_a_evt("post3", 2'd3, 64'd0, 8'h0B);
    step();                                   // edge 5
    chk("post_gone", a_valid, 1'b0);

    // Overwrite channel 1 once while channel 0 holds the arbiter
    set_a(0, 8'h77);
    set_a(1, 8'h55);
    step();                                   // edge 6
    set_a(1, 8'h66);
    step();                                   // edge 7
    chk_a_evt("ovf_c0", 2'd0, 64'd6, 8'h77);
    chk("ovf_drop", a_drop, 32'd1);
`ifdef SICO_RECORDER_OVF_FLAG_EN
    chk("ovf_flag_c0", a_ovf, 1'b0);
`endif
    set_a(1, 8'h99);
    step();                                   // edge 8: slot 1 moved and refilled
    chk_a_evt("ovf_c1a", 2'd1, 64'd7, 8'h66);
`ifdef SICO_RECORDER_OVF_FLAG_EN
    chk("ovf_flag_c1a", a_ovf, 1'b1);
`endif
    step();                                   // edge 9
    chk_a_evt("ovf_c1b", 2'd1, 64'd8, 8'h99);
    chk("refill_drop", a_drop, 32'd1);
`ifdef SICO_RECORDER_OVF_FLAG_EN
    chk("ovf_flag_c1b", a_ovf, 1'b0);
`endif
    step();
    chk("ovf_gone", a_valid, 1'b0);

    // MODE=0, single channel, DEPTH=4, sink blocked for 10 edges
    rst_b = 1'b0;
    for (int k = 0; k < 10; k++) begin
      b_val = 8'(k);
      step();                                 // edge k
      if (k == 3) chk("b_notfull3", b_full, 1'b0);
      if (k == 4) chk("b_full4", b_full, 1'b1);
      if (k == 8) chk("b_drop8", b_drop, 32'd4);
      if (k == 9) chk("b_drop9", b_drop, 32'd5);
    end
    chk("b_head_cycle", b_cycle, 64'd0);
    chk("b_head_val",   b_out,   8'd0);
    chk("b_head_chan",  b_chan,  1'b0);
    b_ready = 1'b1;
    for (int k = 10; k < 15; k++) begin
      logic [63:0] exp_c;
      b_val = 8'(k);
      step();
      exp_c = (k < 13) ? 64'(k - 9) : 64'(k - 4);
      chk("b_drain_valid", b_valid, 1'b1);
      chk("b_drain_cycle", b_cycle, exp_c);
      chk("b_drain_val",   b_out,   exp_c[7:0]);
    end
    chk("b_drop_end", b_drop, 32'd5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
